// File: rtl/ahb_sram_bridge_if.sv
// AHB-Lite slave-side bus bundle used between the interconnect and the SRAM bridge.
interface ahb_sram_bridge_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite to single-cycle word SRAM bridge: zero-wait reads/writes, one wait
// state only when a read address phase collides with a write data phase.
module ahb_sram_bridge #(
  parameter int AW = 11
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_sram_bridge_if.slave     ahb,
  output logic                 ram_EN,
  output logic [3:0]           ram_WE,
  output logic [AW-1:0]        ram_A,
  output logic [31:0]          ram_Di,
  input  logic [31:0]          ram_Do
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RDW  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    mask_q, mask_d;

  logic          accept;
  logic [3:0]    size_mask;
  logic [AW-1:0] haddr_word;
  logic [31:0]   hrdata;
  logic          hreadyout;
  logic          unused_bits;

  // Qualifying with HRESETn keeps the SRAM strobes quiet while reset is held.
  assign accept     = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY & HRESETn;
  assign haddr_word = ahb.HADDR[AW+1:2];
  assign unused_bits = &{1'b0, ahb.HADDR[31:AW+2], ahb.HTRANS[0]};

  always_comb begin
    size_mask = 4'b1111;
    case (ahb.HSIZE)
      3'd0:    size_mask = 4'b0001 << ahb.HADDR[1:0];
      3'd1:    size_mask = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = S_IDLE;
    addr_d    = addr_q;
    mask_d    = mask_q;
    ram_EN    = 1'b0;
    ram_WE    = 4'b0000;
    ram_A     = addr_q;
    hreadyout = 1'b1;
    hrdata    = 32'h0;

    case (state_q)
      S_WR: begin
        ram_EN = 1'b1;
        ram_WE = mask_q;
        ram_A  = addr_q;
      end
      S_RDW: begin
        ram_EN    = 1'b1;
        ram_A     = addr_q;
        hreadyout = 1'b0;
        state_d   = S_RD;
      end
      S_RD: begin
        hrdata = ram_Do;
      end
      default: ;
    endcase

    // A read landing on a write data phase yields to the write and is replayed from addr_q.
    if (accept && (state_q != S_RDW)) begin
      addr_d = haddr_word;
      mask_d = size_mask;
      if (ahb.HWRITE) begin
        state_d = S_WR;
      end else if (state_q == S_WR) begin
        state_d = S_RDW;
      end else begin
        ram_EN  = 1'b1;
        ram_WE  = 4'b0000;
        ram_A   = haddr_word;
        state_d = S_RD;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

  assign ram_Di        = ahb.HWDATA;
  assign ahb.HRDATA    = hrdata;
  assign ahb.HREADYOUT = hreadyout;
  assign ahb.HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Self-checking bench for ahb_sram_bridge: AHB master driver, behavioural SRAM,
// reference memory with a read-data scoreboard.
module tb_ahb_sram_bridge;
  localparam int AW = 11;

  logic          HCLK;
  logic          HRESETn;
  logic          ram_EN;
  logic [3:0]    ram_WE;
  logic [AW-1:0] ram_A;
  logic [31:0]   ram_Di;
  logic [31:0]   ram_Do;

  ahb_sram_bridge_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_sram_bridge #(.AW(AW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (bus),
    .ram_EN  (ram_EN),
    .ram_WE  (ram_WE),
    .ram_A   (ram_A),
    .ram_Di  (ram_Di),
    .ram_Do  (ram_Do)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  // Behavioural synchronous SRAM with byte write enables.
  always @(posedge HCLK) begin
    if (ram_EN) begin
      for (int i = 0; i < 4; i++)
        if (ram_WE[i]) mem[ram_A][8*i +: 8] <= ram_Di[8*i +: 8];
      ram_Do <= mem[ram_A];
    end
  end

  int checks;
  int failures;
  logic [31:0]   exp_q[$];
  logic [3:0]    we_log[$];
  logic [AW-1:0] rd_a_log[$];
  logic          rd_pending;
  int            stall_count;
  int            en_count;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [3:0] laneMask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    if (size == 3'd0) begin
      m = 4'b0000;
      m[a] = 1'b1;
    end else if (size == 3'd1) begin
      m = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      m = 4'b1111;
    end
    return m;
  endfunction

  // Monitor: sample mid-cycle, score read data phases and log SRAM strobes.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      rd_pending <= 1'b0;
    end else begin
      if (rd_pending && bus.HREADYOUT) begin
        if (exp_q.size() == 0) checkOutput("rd_underflow", 32'd1, 32'd0);
        else checkOutput("hrdata", bus.HRDATA, exp_q.pop_front());
      end
      if (!bus.HREADYOUT) stall_count <= stall_count + 1;
      if (ram_EN) begin
        en_count <= en_count + 1;
        if (ram_WE != 4'b0000) we_log.push_back(ram_WE);
        else rd_a_log.push_back(ram_A);
      end
      if (bus.HREADY) rd_pending <= bus.HSEL & bus.HTRANS[1] & ~bus.HWRITE;
    end
  end

  // Drive one address phase, wait for acceptance, then drive its data phase.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata);
    logic       rdy;
    int         guard;
    logic [3:0] m;
    logic [AW-1:0] w;
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
    guard = 0;
    rdy   = 1'b0;
    while (!rdy && guard < 20) begin
      @(negedge HCLK);
      rdy = bus.HREADY;
      @(posedge HCLK);
      guard++;
    end
    if (!rdy) checkOutput("accept_timeout", 32'd0, 32'd1);
    #1;
    w = addr[AW+1:2];
    if (sel && trans[1]) begin
      if (wr) begin
        bus.HWDATA = wdata;
        m = laneMask(size, addr[1:0]);
        for (int i = 0; i < 4; i++)
          if (m[i]) ref_mem[w][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        exp_q.push_back(ref_mem[w]);
      end
    end
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_hreadyout"}, {31'd0, bus.HREADYOUT}, 32'd1);
    checkOutput({tag, "_hresp"},     {31'd0, bus.HRESP},     32'd0);
    checkOutput({tag, "_hrdata"},    bus.HRDATA,             32'd0);
    checkOutput({tag, "_ram_en"},    {31'd0, ram_EN},        32'd0);
    checkOutput({tag, "_ram_we"},    {28'd0, ram_WE},        32'd0);
    checkOutput({tag, "_ram_a"},     {{(32-AW){1'b0}}, ram_A}, 32'd0);
  endtask

  task automatic popWe(input string tag, input logic [3:0] expected);
    if (we_log.size() == 0) checkOutput({tag, "_missing"}, 32'd0, 32'd1);
    else checkOutput(tag, {28'd0, we_log.pop_front()}, {28'd0, expected});
  endtask

  task automatic popRdA(input string tag, input logic [AW-1:0] expected);
    if (rd_a_log.size() == 0) checkOutput({tag, "_missing"}, 32'd0, 32'd1);
    else checkOutput(tag, {{(32-AW){1'b0}}, rd_a_log.pop_front()}, {{(32-AW){1'b0}}, expected});
  endtask

  int s0, e0;

  initial begin
    checks = 0;
    failures = 0;
    rd_pending = 1'b0;
    stall_count = 0;
    en_count = 0;
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HADDR = 32'h0; bus.HSIZE = 3'd2; bus.HWDATA = 32'h0;
    HRESETn = 1'b0;
    #12;
    checkResetOutputs("reset");
    #10 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Word write then separate read, no stalls
    s0 = stall_count;
    applyStimulus(1'b1, 2'b10, 1'b1, 32'h000, 3'd2, 32'hDEADBEEF);
    idleCycle();
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h000, 3'd2, 32'h0);
    idleCycle();
    popWe("s1_we", 4'b1111);
    checkOutput("s1_stalls", stall_count - s0, 32'd0);
    rd_a_log.delete();

    // Byte writes into a zero word
    applyStimulus(1'b1, 2'b10, 1'b1, 32'h100, 3'd2, 32'h00000000);
    applyStimulus(1'b1, 2'b10, 1'b1, 32'h103, 3'd0, 32'h11000000);
    applyStimulus(1'b1, 2'b11, 1'b1, 32'h101, 3'd0, 32'h00002200);
    idleCycle();
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 3'd2, 32'h0);
    idleCycle();
    popWe("s2_we_word", 4'b1111);
    popWe("s2_we_b3", 4'b1000);
    popWe("s2_we_b1", 4'b0010);
    checkOutput("s2_ref", ref_mem[11'h040], 32'h11002200);
    applyStimulus(1'b1, 2'b10, 1'b1, 32'h202, 3'd1, 32'hABCD0000);
    idleCycle();
    popWe("s2_we_half", 4'b1100);
    rd_a_log.delete();

    // Write immediately followed by read of the same word: one wait state
    s0 = stall_count;
    applyStimulus(1'b1, 2'b10, 1'b1, 32'h7FC, 3'd2, 32'h0BADF00D);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h7FC, 3'd2, 32'h0);
    idleCycle();
    idleCycle();
    checkOutput("s3_stalls", stall_count - s0, 32'd1);
    popWe("s3_we", 4'b1111);
    popRdA("s3_deferred_a", 11'h1FF);

    // Bank 1 setup, then back-to-back reads including an alias
    applyStimulus(1'b1, 2'b10, 1'b1, 32'h1000, 3'd2, 32'hCAFEF00D);
    idleCycle();
    void'(we_log.pop_front());
    rd_a_log.delete();
    s0 = stall_count;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000, 3'd2, 32'h0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h1000, 3'd2, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h2000, 3'd2, 32'h0);
    idleCycle();
    checkOutput("s4_stalls", stall_count - s0, 32'd0);
    popRdA("s4_a0", 11'h000);
    popRdA("s4_a1", 11'h400);
    popRdA("s4_alias", 11'h000);

    // Non-accepted transfers cause no SRAM access
    s0 = stall_count;
    e0 = en_count;
    applyStimulus(1'b1, 2'b00, 1'b1, 32'h000, 3'd2, 32'h12345678);
    applyStimulus(1'b1, 2'b01, 1'b1, 32'h000, 3'd2, 32'h12345678);
    applyStimulus(1'b0, 2'b10, 1'b1, 32'h000, 3'd2, 32'h12345678);
    bus.HWDATA = 32'h12345678;
    idleCycle();
    checkOutput("s5_en", en_count - e0, 32'd0);
    checkOutput("s5_stalls", stall_count - s0, 32'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h000, 3'd2, 32'h0);
    idleCycle();
    rd_a_log.delete();

    // Reset asserted during the deferred-read stall
    applyStimulus(1'b1, 2'b10, 1'b1, 32'h040, 3'd2, 32'h5A5A5A5A);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h040, 3'd2, 32'h0);
    #2;
    checkOutput("s6_stall", {31'd0, bus.HREADYOUT}, 32'd0);
    HRESETn = 1'b0;
    #1;
    checkResetOutputs("s6_rst");
    exp_q.delete();
    @(negedge HCLK);
    #2 HRESETn = 1'b1;
    we_log.delete();
    rd_a_log.delete();
    s0 = stall_count;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000, 3'd2, 32'h0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h1000, 3'd2, 32'h0);
    idleCycle();
    checkOutput("s6_stalls", stall_count - s0, 32'd0);
    popRdA("s6_a0", 11'h000);
    popRdA("s6_a1", 11'h400);

    idleCycle();
    idleCycle();
    checkOutput("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
